// File: rtl/regfile_pkg.sv
// Shared constants and types for the multi-port integer register file.
package regfile_pkg;

  localparam int REGFILE_DW    = 32;
  localparam int REGFILE_DEPTH = 32;
  localparam int REGFILE_NR    = 8;
  localparam int REGFILE_NW    = 5;
  localparam int REGFILE_AW    = $clog2(REGFILE_DEPTH);

  typedef logic [REGFILE_AW-1:0] reg_addr_t;
  typedef logic [REGFILE_DW-1:0] reg_data_t;

endpackage

// File: rtl/regfile_mp_if.sv
// Read/write/scoreboard bus of regfile_mp; the issue/writeback logic is the master.
interface regfile_mp_if
  import regfile_pkg::*;
#(
  parameter int DW    = REGFILE_DW,
  parameter int DEPTH = REGFILE_DEPTH,
  parameter int AW    = $clog2(DEPTH),
  parameter int NR    = REGFILE_NR,
  parameter int NW    = REGFILE_NW
) ();

  logic [NR-1:0]    rd_en;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0]    rd_busy;
  logic [NW-1:0]    wr_en;
  logic [NW*AW-1:0] wr_addr;
  logic [NW*DW-1:0] wr_data;
  logic             rsv_en;
  logic [AW-1:0]    rsv_addr;
  logic             flush;
  logic [DEPTH-1:0] busy_vec;

  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, flush,
    input  rd_data, rd_busy, busy_vec
  );

  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, flush,
    output rd_data, rd_busy, busy_vec
  );

endinterface

// File: rtl/regfile_wr_sel.sv
// Write-port selector for one register index: flags any enabled port hitting idx and
// returns the data of the highest-indexed such port.
module regfile_wr_sel
  import regfile_pkg::*;
#(
  parameter int DW = REGFILE_DW,
  parameter int AW = REGFILE_AW,
  parameter int NW = REGFILE_NW
) (
  input  logic [NW-1:0]    wr_en,
  input  logic [NW*AW-1:0] wr_addr,
  input  logic [NW*DW-1:0] wr_data,
  input  logic [AW-1:0]    idx,
  output logic             hit,
  output logic [DW-1:0]    data
);

  logic [NW-1:0] match_s;

  // Per-port address match against this index
  always_comb begin
    match_s = '0;
    for (int j = 0; j < NW; j++) begin
      match_s[j] = wr_en[j] && (wr_addr[j*AW +: AW] == idx);
    end
  end

  // Later ports overwrite earlier ones, so the highest matching port wins
  always_comb begin
    hit  = |match_s;
    data = '0;
    for (int j = 0; j < NW; j++) begin
      data = match_s[j] ? wr_data[j*DW +: DW] : data;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with per-register busy scoreboard.
// Optional macro WR_BYPASS_EN forwards same-cycle write data to the read ports.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DW    = REGFILE_DW,
  parameter int DEPTH = REGFILE_DEPTH,
  parameter int AW    = $clog2(DEPTH),
  parameter int NR    = REGFILE_NR,
  parameter int NW    = REGFILE_NW
) (
  input logic         clk,
  input logic         rst_n,
  regfile_mp_if.slave bus
);

  logic [DW-1:0]    mem_r [DEPTH];
  logic [DEPTH-1:0] busy_r;
  logic [DEPTH-1:0] wr_hit_s;
  logic [DW-1:0]    wr_sel_data_s [DEPTH];
  logic [NR*DW-1:0] rd_data_s;
  logic [NR-1:0]    rd_busy_s;

  for (genvar r = 0; r < DEPTH; r++) begin : g_wr_sel
    regfile_wr_sel #(.DW(DW), .AW(AW), .NW(NW)) u_wr_sel (
      .wr_en   (bus.wr_en),
      .wr_addr (bus.wr_addr),
      .wr_data (bus.wr_data),
      .idx     (AW'(r)),
      .hit     (wr_hit_s[r]),
      .data    (wr_sel_data_s[r])
    );
  end

  // Register storage update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < DEPTH; r++) begin
        mem_r[r] <= '0;
      end
    end else begin
      for (int r = 0; r < DEPTH; r++) begin
        if (wr_hit_s[r]) begin
          mem_r[r] <= wr_sel_data_s[r];
        end
      end
    end
  end

  // Scoreboard: flush beats reserve, reserve beats writeback clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= '0;
    end else if (bus.flush) begin
      busy_r <= '0;
    end else begin
      for (int r = 0; r < DEPTH; r++) begin
        if (bus.rsv_en && (bus.rsv_addr == AW'(r))) begin
          busy_r[r] <= 1'b1;
        end else if (wr_hit_s[r]) begin
          busy_r[r] <= 1'b0;
        end
      end
    end
  end

`ifdef WR_BYPASS_EN
  logic [NR-1:0] byp_hit_s;
  logic [DW-1:0] byp_data_s [NR];

  for (genvar i = 0; i < NR; i++) begin : g_byp_sel
    regfile_wr_sel #(.DW(DW), .AW(AW), .NW(NW)) u_byp_sel (
      .wr_en   (bus.wr_en),
      .wr_addr (bus.wr_addr),
      .wr_data (bus.wr_data),
      .idx     (bus.rd_addr[i*AW +: AW]),
      .hit     (byp_hit_s[i]),
      .data    (byp_data_s[i])
    );
  end
`endif

  // Combinational read ports; disabled ports drive zero
  always_comb begin
    rd_data_s = '0;
    rd_busy_s = '0;
    for (int i = 0; i < NR; i++) begin
      if (bus.rd_en[i]) begin
`ifdef WR_BYPASS_EN
        if (byp_hit_s[i]) begin
          rd_data_s[i*DW +: DW] = byp_data_s[i];
          rd_busy_s[i]          = bus.rsv_en && (bus.rsv_addr == bus.rd_addr[i*AW +: AW]);
        end else begin
          rd_data_s[i*DW +: DW] = mem_r[bus.rd_addr[i*AW +: AW]];
          rd_busy_s[i]          = busy_r[bus.rd_addr[i*AW +: AW]];
        end
`else
        rd_data_s[i*DW +: DW] = mem_r[bus.rd_addr[i*AW +: AW]];
        rd_busy_s[i]          = busy_r[bus.rd_addr[i*AW +: AW]];
`endif
      end else begin
        rd_data_s[i*DW +: DW] = '0;
        rd_busy_s[i]          = 1'b0;
      end
    end
  end

  assign bus.rd_data  = rd_data_s;
  assign bus.rd_busy  = rd_busy_s;
  assign bus.busy_vec = busy_r;

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp; expectations follow WR_BYPASS_EN when it is defined.
module tb_regfile_mp;
  import regfile_pkg::*;

  localparam int DW    = 32;
  localparam int DEPTH = 32;
  localparam int AW    = 5;
  localparam int NR    = 8;
  localparam int NW    = 5;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  regfile_mp_if #(.DW(DW), .DEPTH(DEPTH), .AW(AW), .NR(NR), .NW(NW)) bus ();

  regfile_mp #(.DW(DW), .DEPTH(DEPTH), .AW(AW), .NR(NR), .NW(NW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string       name;
    int          kind;   // 0 rd_data, 1 rd_busy, 2 busy_vec
    int          port;
    logic [31:0] exp;
  } sb_t;

  sb_t         sbq[$];
  sb_t         cur;
  logic [31:0] act;
  int          checks = 0;
  int          errors = 0;

  // Monitor: compare every pending expectation against the outputs mid-cycle
  always @(negedge clk) begin
    while (sbq.size() > 0) begin
      cur = sbq.pop_front();
      case (cur.kind)
        0:       act = bus.rd_data[cur.port*DW +: DW];
        1:       act = {31'd0, bus.rd_busy[cur.port]};
        default: act = bus.busy_vec;
      endcase
      checks++;
      if (act !== cur.exp) begin
        errors++;
        $display("FAIL %s port %0d: got 0x%08h expected 0x%08h", cur.name, cur.port, act, cur.exp);
      end
    end
  end

  task automatic clear_inputs();
    bus.rd_en    = '0;
    bus.rd_addr  = '0;
    bus.wr_en    = '0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.rsv_en   = 1'b0;
    bus.rsv_addr = '0;
    bus.flush    = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  task automatic set_wr(input int j, input reg_addr_t a, input reg_data_t d);
    bus.wr_en[j]            = 1'b1;
    bus.wr_addr[j*AW +: AW] = a;
    bus.wr_data[j*DW +: DW] = d;
  endtask

  task automatic set_rd(input int i, input reg_addr_t a);
    bus.rd_en[i]            = 1'b1;
    bus.rd_addr[i*AW +: AW] = a;
  endtask

  task automatic set_rsv(input reg_addr_t a);
    bus.rsv_en   = 1'b1;
    bus.rsv_addr = a;
  endtask

  task automatic expect_rd(input string name, input int port, input reg_data_t d, input logic b);
    sbq.push_back('{name: {name, "_data"}, kind: 0, port: port, exp: d});
    sbq.push_back('{name: {name, "_busy"}, kind: 1, port: port, exp: {31'd0, b}});
  endtask

  task automatic expect_bv(input string name, input logic [31:0] v);
    sbq.push_back('{name: name, kind: 2, port: 0, exp: v});
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    step();
    set_rd(0, 5'd5);
    expect_rd("reset_rd", 0, 32'h0, 1'b0);
    expect_bv("reset_bv", 32'h0);
    step();
    rst_n = 1'b1;

    // Load reg5 and reserve reg6, then pull reset with no clock edge before the check
    set_wr(0, 5'd5, 32'hDEADBEEF);
    set_rsv(5'd6);
    step();
    set_rd(0, 5'd5);
    expect_rd("pre_reset_rd", 0, 32'hDEADBEEF, 1'b0);
    expect_bv("pre_reset_bv", 32'h0000_0040);
    step();
    rst_n = 1'b0;
    set_wr(1, 5'd8, 32'h0000_1234);
    set_rsv(5'd8);
    set_rd(0, 5'd5);
    expect_rd("async_reset_rd", 0, 32'h0, 1'b0);
    expect_bv("async_reset_bv", 32'h0);
    step();
    rst_n = 1'b1;
    set_rd(0, 5'd8);
    expect_rd("reset_discard_rd", 0, 32'h0, 1'b0);
    expect_bv("reset_discard_bv", 32'h0);

    // Port priority on reg3; ports 2,3 target reg3 but are disabled
    step();
    set_wr(0, 5'd3, 32'h11);
    set_wr(1, 5'd3, 32'h22);
    set_wr(2, 5'd3, 32'h33);
    set_wr(3, 5'd3, 32'h44);
    set_wr(4, 5'd3, 32'h55);
    bus.wr_en[2] = 1'b0;
    bus.wr_en[3] = 1'b0;
    step();
    set_rd(2, 5'd3);
    expect_rd("prio_rd", 2, 32'h55, 1'b0);

    // Load reg k = 0x100+k and read all ports, two of them disabled
    step();
    for (int k = 0; k < 5; k++) set_wr(k, reg_addr_t'(k), reg_data_t'(32'h100 + k));
    step();
    for (int k = 0; k < 3; k++) set_wr(k, reg_addr_t'(5 + k), reg_data_t'(32'h105 + k));
    step();
    for (int i = 0; i < NR; i++) set_rd(i, reg_addr_t'(i));
    bus.rd_en[3] = 1'b0;
    bus.rd_en[6] = 1'b0;
    for (int i = 0; i < NR; i++)
      expect_rd("allports_rd", i, (i == 3 || i == 6) ? 32'h0 : 32'h100 + i, 1'b0);

    // Scoreboard reserve / writeback clear / same-cycle reserve+write
    step();
    set_rsv(5'd7);
    step();
    set_rd(0, 5'd7);
    expect_rd("rsv7_rd", 0, 32'h107, 1'b1);
    expect_bv("rsv7_bv", 32'h0000_0080);
    step();
    set_wr(3, 5'd7, 32'h7);
    step();
    set_rd(0, 5'd7);
    expect_rd("wb7_rd", 0, 32'h7, 1'b0);
    expect_bv("wb7_bv", 32'h0);
    step();
    set_rsv(5'd9);
    set_wr(1, 5'd9, 32'h99);
    step();
    set_rd(0, 5'd9);
    expect_rd("rsvwr9_rd", 0, 32'h99, 1'b1);
    expect_bv("rsvwr9_bv", 32'h0000_0200);

    // Flush together with a reserve and a write
    step();
    set_rsv(5'd1);
    step();
    set_rsv(5'd2);
    step();
    set_rsv(5'd3);
    step();
    bus.flush = 1'b1;
    set_rsv(5'd4);
    set_wr(0, 5'd4, 32'h44);
    expect_bv("pre_flush_bv", 32'h0000_020E);
    step();
    set_rd(0, 5'd4);
    expect_rd("flush_rd4", 0, 32'h44, 1'b0);
    expect_bv("flush_bv", 32'h0);

    // Same-cycle write and read of reg10 (with reserve), plus an unrelated read
    step();
    set_wr(2, 5'd10, 32'hCAFE);
    set_rsv(5'd10);
    set_rd(5, 5'd10);
    set_rd(1, 5'd0);
`ifdef WR_BYPASS_EN
    expect_rd("byp10_rd", 5, 32'hCAFE, 1'b1);
`else
    expect_rd("byp10_rd", 5, 32'h0, 1'b0);
`endif
    expect_rd("byp_other_rd", 1, 32'h100, 1'b0);
    step();
    set_rd(5, 5'd10);
    expect_rd("after10_rd", 5, 32'hCAFE, 1'b1);

    // Bypass priority on reg11 while a writeback clears reg10
    step();
    set_wr(0, 5'd11, 32'hA);
    set_wr(1, 5'd10, 32'hD00D);
    set_wr(3, 5'd11, 32'hB);
    set_rd(2, 5'd11);
`ifdef WR_BYPASS_EN
    expect_rd("byp11_rd", 2, 32'hB, 1'b0);
`else
    expect_rd("byp11_rd", 2, 32'h0, 1'b0);
`endif
    step();
    set_rd(2, 5'd11);
    set_rd(4, 5'd10);
    expect_rd("after11_rd", 2, 32'hB, 1'b0);
    expect_rd("clear10_rd", 4, 32'hD00D, 1'b0);
    expect_bv("final_bv", 32'h0);

    step();
    @(negedge clk);
    #1;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port integer register file for the multi-issue pipeline. It replaces the strobe-edge-written, tri-stated register array with a single-clock design:
- NR combinational read ports and NW synchronous write ports, with deterministic conflict priority.
- A per-register busy scoreboard (reserve at issue, clear at writeback, flush on redirect) that the issue stage uses for hazard detection.

Parameters:
DW, 32, data width in bits
DEPTH, 32, number of architectural registers (power of two)
AW, $clog2(DEPTH), register address width
NR, 8, number of read ports
NW, 5, number of write ports

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
rd_en  input  NR  per-port read enable
rd_addr  input  NR*AW  read addresses, port i at [i*AW +: AW]
rd_data  output  NR*DW  read data, port i at [i*DW +: DW]
rd_busy  output  NR  busy bit of the addressed register, per port
wr_en  input  NW  per-port write enable
wr_addr  input  NW*AW  write addresses
wr_data  input  NW*DW  write data
rsv_en  input  1  reserve request (issue marks destination pending)
rsv_addr  input  AW  register to reserve
flush  input  1  synchronous clear of all busy bits
busy_vec  output  DEPTH  full scoreboard view

Behaviour:
- Reset (rst_n low, asynchronous): all DEPTH registers = 0; all busy bits = 0. Consequently rd_data = 0, rd_busy = 0, busy_vec = 0. Reset mid-operation discards any write or reserve in that cycle.
- Read, 0-cycle latency, combinational:
  - rd_en[i]=1: rd_data[i] = reg[rd_addr[i]] and rd_busy[i] = busy[rd_addr[i]].
  - rd_en[i]=0: both driven to 0. No high-impedance outputs.
- Write, 1-cycle latency: on the rising edge with wr_en[j]=1, reg[wr_addr[j]] <= wr_data[j].
- Write conflict: several enabled ports target the same address in one cycle → the highest-indexed port j wins; the others are dropped silently.
- Scoreboard update per rising edge, in priority order:
  1. flush=1 → all busy <= 0; rsv_en and write-clear are ignored that cycle. Register writes still occur.
  2. rsv_en=1 → busy[rsv_addr] <= 1.
  3. Any wr_en[j] with wr_addr[j]=a and a != rsv_addr (when rsv_en=1) → busy[a] <= 0.
  - Reserve and write to the same register in the same cycle → busy ends at 1, because the new producer wins. The data write still occurs.
- Busy updates are visible on rd_busy and busy_vec the cycle after the edge. The scoreboard never blocks writes; writing a non-busy register is legal and leaves busy at 0.
- All registers, including register 0, are ordinary storage. Hardwiring register 0 is the instruction decoder's responsibility.
- Width rules:
  - Addresses are exactly AW bits; no out-of-range addresses exist.
  - Data is stored unsigned, raw DW bits; no sign handling inside the block.

Optional Feature:
Macro WR_BYPASS_EN.
- Defined: write-to-read forwarding. If rd_en[i]=1 and any wr_en[j]=1 with wr_addr[j]=rd_addr[i] in the same cycle, rd_data[i] returns the winning (highest j) wr_data[j] combinationally. rd_busy[i] returns 0 unless rsv_en=1 with rsv_addr=rd_addr[i], in which case it returns 1.
- Undefined: reads return the stored value and stored busy bit; new data is visible the cycle after the write.

Decomposition:
- Shared package regfile_pkg holds:
  - default constants REGFILE_DW=32, REGFILE_DEPTH=32, REGFILE_NR=8, REGFILE_NW=5;
  - typedef reg_addr_t (AW bits);
  - typedef reg_data_t (DW bits).
- One sub-module regfile_wr_sel: for a single register index it takes wr_en/wr_addr/wr_data and outputs hit and the highest-priority data. It is instantiated DEPTH times by generate, and reused by the bypass path as a per-read-port selector.

Test Plan:
1. Reset: assert rst_n=0 mid-run after writing reg5=0xDEADBEEF → rd_data for addr 5 = 0 and busy_vec = 0 immediately, without waiting for a clock edge.
2. Port priority: same cycle wr_en=5'b10011 writing reg3 with 0x11 (port0), 0x22 (port1), 0x55 (port4) → next cycle reads reg3 = 0x55.
3. All ports: NR=8 simultaneous reads of regs 0..7 after loading reg k=0x100+k → each rd_data[i] = 0x100+i. Ports with rd_en=0 read 0.
4. Scoreboard: rsv reg7 → busy_vec[7]=1 next cycle. Write reg7=0x7 → busy clears next cycle. Same-cycle rsv reg9 plus write reg9 → busy[9]=1 and reg9 holds the written data.
5. Flush: reserve regs 1,2,3 over 3 cycles, then flush=1 together with rsv_en reg4 → busy_vec = 0 afterwards, and reg4 is not busy.
6. Bypass: write reg10=0xCAFE while reading reg10 in the same cycle → with WR_BYPASS_EN, rd_data = 0xCAFE that cycle; without it, rd_data = old value that cycle and 0xCAFE the next cycle.
